// File: rtl/xctcmsg_pkg.sv
// Shared types for the xctcmsg receive path: message layout, receive-queue
// request, writeback result and the receive matcher state encoding.
package xctcmsg_pkg;

  localparam int META_W = 64;
  localparam int DATA_W = 64;
  localparam int PT_W   = 8;

  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] addr;
  } message_metadata_t;

  typedef struct packed {
    message_metadata_t   meta;
    logic [DATA_W-1:0]   data;
  } message_t;

  // 128-bit payload delivered by the network interface
  typedef struct packed {
    message_t message;
  } interface_receive_data_t;

  typedef struct packed {
    logic              is_avail;
    message_metadata_t meta;
    message_metadata_t meta_mask;
    logic [PT_W-1:0]   passthrough;
  } receive_queue_data_t;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [PT_W-1:0]   passthrough;
  } writeback_arbiter_data_t;

  typedef enum logic [1:0] {
    IDLE,
    MATCH,
    RESP
  } recv_matcher_state_t;

  // Mask bit set means the corresponding metadata bit must be equal.
  function automatic logic meta_match(message_metadata_t e,
                                      message_metadata_t m,
                                      message_metadata_t mask);
    logic [META_W-1:0] e_v;
    logic [META_W-1:0] m_v;
    logic [META_W-1:0] k_v;
    e_v = e;
    m_v = m;
    k_v = mask;
    return ((e_v ^ m_v) & k_v) == '0;
  endfunction

endpackage

// File: rtl/xctcmsg_oldest_match_finder.sv
// Find-first-set over the buffer match vector; index 0 is the oldest entry.
module xctcmsg_oldest_match_finder #(
  parameter  int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match_vec_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  // scan from the newest end so the lowest set bit wins
  always_comb begin
    hit_o = |match_vec_i;
    idx_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_vec_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/xctcmsg_receive_matcher.sv
// Receive matcher: buffers interface messages in a collapsing queue and
// services RECV (remove oldest match) / AVAIL (report match) requests.
module xctcmsg_receive_matcher
  import xctcmsg_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    intf_recv_valid_i,
  input  interface_receive_data_t intf_recv_data_i,
  output logic                    intf_recv_ready_o,
  input  logic                    rq_valid_i,
  input  receive_queue_data_t     rq_data_i,
  output logic                    rq_ready_o,
  output logic                    wb_valid_o,
  output writeback_arbiter_data_t wb_data_o,
  input  logic                    wb_ready_i,
  output logic [CNT_W-1:0]        occupancy_o
);

  message_t                buf_q [DEPTH];
  message_t                buf_d [DEPTH];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  recv_matcher_state_t     state_q, state_d;
  receive_queue_data_t     req_q, req_d;
  logic                    wb_valid_q, wb_valid_d;
  writeback_arbiter_data_t wb_data_q, wb_data_d;

  logic [DEPTH-1:0]        match_vec;
  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  logic                    pop;
  logic                    push;

  // ready depends only on the registered count; a same-cycle pop does not help
  assign intf_recv_ready_o = (cnt_q < CNT_W'(DEPTH));
  assign push              = intf_recv_valid_i & intf_recv_ready_o;
  assign rq_ready_o        = (state_q == IDLE);
  assign wb_valid_o        = wb_valid_q;
  assign wb_data_o         = wb_data_q;
  assign occupancy_o       = cnt_q;

  // only entries present at the start of the cycle are eligible
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = (CNT_W'(i) < cnt_q) &&
                     meta_match(buf_q[i].meta, req_q.meta, req_q.meta_mask);
    end
  end

  xctcmsg_oldest_match_finder #(.DEPTH(DEPTH)) u_finder (
    .match_vec_i (match_vec),
    .hit_o       (hit),
    .idx_o       (hit_idx)
  );

  // request sequencing: latch, match (blocking for RECV), hold result
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (rq_valid_i) begin
          req_d   = rq_data_i;
          state_d = MATCH;
        end
      end
      MATCH: begin
        if (req_q.is_avail) begin
          wb_data_d.value       = {{(DATA_W-1){1'b0}}, hit};
          wb_data_d.passthrough = req_q.passthrough;
          wb_valid_d            = 1'b1;
          state_d               = RESP;
        end else if (hit) begin
          pop                   = 1'b1;
          wb_data_d.value       = buf_q[hit_idx].data;
          wb_data_d.passthrough = req_q.passthrough;
          wb_valid_d            = 1'b1;
          state_d               = RESP;
        end
      end
      RESP: begin
        if (wb_ready_i) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // collapse on pop first, then append the incoming message at the new tail
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(hit_idx)) buf_d[i] = buf_q[i+1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(cnt_q) - 1) buf_d[i] = '0;
      end
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(cnt_d)) buf_d[i] = intf_recv_data_i.message;
      end
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // state, buffer and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      req_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule

// File: tb/tb_xctcmsg_receive_matcher.sv
// Self-checking bench for xctcmsg_receive_matcher: directed scenarios plus a
// randomized phase, all checked against a queue-based reference model.
module tb_xctcmsg_receive_matcher;
  import xctcmsg_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    intf_valid;
  interface_receive_data_t intf_data;
  logic                    intf_ready;
  logic                    rq_valid;
  receive_queue_data_t     rq_data;
  logic                    rq_ready;
  logic                    wb_valid;
  writeback_arbiter_data_t wb_data;
  logic                    wb_ready;
  logic [CNT_W-1:0]        occupancy;

  always #5 clk = ~clk;

  xctcmsg_receive_matcher #(.DEPTH(DEPTH)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .intf_recv_valid_i (intf_valid),
    .intf_recv_data_i  (intf_data),
    .intf_recv_ready_o (intf_ready),
    .rq_valid_i        (rq_valid),
    .rq_data_i         (rq_data),
    .rq_ready_o        (rq_ready),
    .wb_valid_o        (wb_valid),
    .wb_data_o         (wb_data),
    .wb_ready_i        (wb_ready),
    .occupancy_o       (occupancy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_val(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  message_t                mq[$];
  bit                      m_pend;
  bit                      m_resp;
  bit                      chk_en = 1'b0;
  receive_queue_data_t     m_req;
  writeback_arbiter_data_t m_wb;

  function automatic bit ref_match(message_t e, receive_queue_data_t r);
    return (((e.meta.tag  ^ r.meta.tag)  & r.meta_mask.tag)  == 32'd0) &&
           (((e.meta.addr ^ r.meta.addr) & r.meta_mask.addr) == 32'd0);
  endfunction

  always @(posedge clk) begin : ref_model
    bit do_push;
    bit do_acc;
    int hit_i;
    if (rst) begin
      mq.delete();
      m_pend = 1'b0;
      m_resp = 1'b0;
      chk_en = 1'b1;
    end else begin
      do_push = intf_valid && (mq.size() < DEPTH);
      do_acc  = rq_valid && !m_pend && !m_resp;
      if (m_pend) begin
        hit_i = -1;
        for (int i = 0; i < mq.size(); i++)
          if (hit_i < 0 && ref_match(mq[i], m_req)) hit_i = i;
        if (m_req.is_avail) begin
          m_wb.value       = (hit_i >= 0) ? 64'd1 : 64'd0;
          m_wb.passthrough = m_req.passthrough;
          m_resp = 1'b1;
          m_pend = 1'b0;
        end else if (hit_i >= 0) begin
          m_wb.value       = mq[hit_i].data;
          m_wb.passthrough = m_req.passthrough;
          mq.delete(hit_i);
          m_resp = 1'b1;
          m_pend = 1'b0;
        end
      end else if (m_resp && wb_ready) begin
        m_resp = 1'b0;
      end
      if (do_push) mq.push_back(intf_data.message);
      if (do_acc) begin
        m_pend = 1'b1;
        m_req  = rq_data;
      end
    end
  end

  // continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk_val("intf_ready", 128'(intf_ready), 128'(mq.size() < DEPTH));
      chk_val("rq_ready",   128'(rq_ready),   128'(!m_pend && !m_resp));
      chk_val("wb_valid",   128'(wb_valid),   128'(m_resp));
      chk_val("occupancy",  128'(occupancy),  128'(mq.size()));
      if (m_resp) chk_val("wb_data", 128'(wb_data), 128'(m_wb));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_msg(logic [31:0] tag, logic [31:0] addr, logic [63:0] data);
    intf_valid                   = 1'b1;
    intf_data.message.meta.tag   = tag;
    intf_data.message.meta.addr  = addr;
    intf_data.message.data       = data;
    step();
    intf_valid = 1'b0;
  endtask

  task automatic set_req(bit avail, logic [31:0] tag, logic [31:0] addr, logic [63:0] mask);
    rq_data.is_avail    = avail;
    rq_data.meta.tag    = tag;
    rq_data.meta.addr   = addr;
    rq_data.meta_mask   = mask;
    rq_data.passthrough = 8'($urandom);
  endtask

  task automatic send_req(bit avail, logic [31:0] tag, logic [31:0] addr, logic [63:0] mask);
    int n = 0;
    while (!rq_ready && n < 50) begin
      step();
      n++;
    end
    if (!rq_ready) chk_val("rq_ready_timeout", 128'(0), 128'(1));
    set_req(avail, tag, addr, mask);
    rq_valid = 1'b1;
    step();
    rq_valid = 1'b0;
  endtask

  task automatic get_resp(string tag, logic [63:0] exp);
    int n = 0;
    while (!wb_valid && n < 60) begin
      step();
      n++;
    end
    if (!wb_valid) chk_val({tag, "_timeout"}, 128'(0), 128'(1));
    else           chk_val(tag, 128'(wb_data.value), 128'(exp));
    step();
  endtask

  task automatic chk_reset_outputs(string tag);
    chk_val({tag, "_wb_valid"},   128'(wb_valid),   128'(0));
    chk_val({tag, "_wb_data"},    128'(wb_data),    128'(0));
    chk_val({tag, "_rq_ready"},   128'(rq_ready),   128'(1));
    chk_val({tag, "_intf_ready"}, 128'(intf_ready), 128'(1));
    chk_val({tag, "_occupancy"},  128'(occupancy),  128'(0));
  endtask

  localparam logic [63:0] MASK_ALL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MASK_TAG = 64'hFFFF_FFFF_0000_0000;

  initial begin
    logic [63:0] v0;
    rst        = 1'b1;
    intf_valid = 1'b0;
    intf_data  = '0;
    rq_valid   = 1'b0;
    rq_data    = '0;
    wb_ready   = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // 1: single message, full mask, latency
    push_msg(32'h5, 32'h10, 64'hDEAD);
    chk_val("t1_occ_before", 128'(occupancy), 128'(1));
    set_req(1'b0, 32'h5, 32'h10, MASK_ALL);
    rq_valid = 1'b1;
    step();
    rq_valid = 1'b0;
    chk_val("t1_wb_valid_early", 128'(wb_valid), 128'(0));
    step();
    chk_val("t1_wb_valid", 128'(wb_valid), 128'(1));
    chk_val("t1_value", 128'(wb_data.value), 128'(64'hDEAD));
    chk_val("t1_occ_after", 128'(occupancy), 128'(0));
    wb_ready = 1'b1;
    step();

    // 2: oldest-first among equal tags
    push_msg(32'h7, 32'h1, 64'hA);
    push_msg(32'h7, 32'h2, 64'hB);
    send_req(1'b0, 32'h7, 32'h0, MASK_TAG);
    get_resp("t2_first", 64'hA);
    send_req(1'b0, 32'h7, 32'h0, MASK_TAG);
    get_resp("t2_second", 64'hB);

    // 3: AVAIL on empty and on one entry, no removal
    send_req(1'b1, 32'h3, 32'h0, MASK_ALL);
    get_resp("t3_avail_empty", 64'd0);
    push_msg(32'h3, 32'h0, 64'h77);
    send_req(1'b1, 32'h3, 32'h0, MASK_ALL);
    get_resp("t3_avail_hit", 64'd1);
    chk_val("t3_occ", 128'(occupancy), 128'(1));
    send_req(1'b0, 32'h0, 32'h0, 64'd0);
    get_resp("t3_drain", 64'h77);

    // 4: blocking RECV satisfied by a later push
    send_req(1'b0, 32'h9, 32'h0, MASK_TAG);
    for (int i = 0; i < 3; i++) begin
      chk_val("t4_blocked", 128'(wb_valid), 128'(0));
      step();
    end
    push_msg(32'h9, 32'h0, 64'h42);
    chk_val("t4_not_same_cycle", 128'(wb_valid), 128'(0));
    step();
    chk_val("t4_wb_valid", 128'(wb_valid), 128'(1));
    chk_val("t4_value", 128'(wb_data.value), 128'(64'h42));
    step();

    // 5: full buffer, pop entry 1 while a fifth push is offered
    for (int i = 0; i < DEPTH; i++) push_msg(32'(10 + i), 32'h0, 64'(i));
    chk_val("t5_full_ready", 128'(intf_ready), 128'(0));
    set_req(1'b0, 32'd11, 32'h0, MASK_TAG);
    rq_valid = 1'b1;
    step();
    rq_valid = 1'b0;
    intf_valid                  = 1'b1;
    intf_data.message.meta.tag  = 32'd14;
    intf_data.message.meta.addr = 32'h0;
    intf_data.message.data      = 64'h99;
    step();
    intf_valid = 1'b0;
    chk_val("t5_ready_after_pop", 128'(intf_ready), 128'(1));
    chk_val("t5_occ", 128'(occupancy), 128'(3));
    chk_val("t5_value", 128'(wb_data.value), 128'(64'd1));
    step();
    send_req(1'b0, 32'h0, 32'h0, 64'd0);
    get_resp("t5_order0", 64'd0);
    send_req(1'b0, 32'h0, 32'h0, 64'd0);
    get_resp("t5_order2", 64'd2);
    send_req(1'b0, 32'h0, 32'h0, 64'd0);
    get_resp("t5_order3", 64'd3);

    // 6: held result under back-pressure, then reset mid-MATCH
    push_msg(32'd20, 32'h0, 64'h55);
    wb_ready = 1'b0;
    send_req(1'b0, 32'd20, 32'h0, MASK_ALL);
    step();
    v0 = wb_data.value;
    for (int i = 0; i < 5; i++) begin
      chk_val("t6_hold_valid", 128'(wb_valid), 128'(1));
      chk_val("t6_hold_value", 128'(wb_data.value), 128'(64'h55));
      chk_val("t6_hold_stable", 128'(wb_data.value), 128'(v0));
      chk_val("t6_rq_ready", 128'(rq_ready), 128'(0));
      step();
    end
    wb_ready = 1'b1;
    step();
    chk_val("t6_released", 128'(wb_valid), 128'(0));
    push_msg(32'd21, 32'h0, 64'h66);
    send_req(1'b0, 32'd99, 32'h0, MASK_TAG);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("t6_midrst");

    // randomized phase against the model
    for (int c = 0; c < 2000; c++) begin
      rst        = (c % 400 == 399);
      intf_valid = ($urandom_range(0, 9) < 4);
      intf_data.message.meta.tag  = 32'($urandom_range(0, 3));
      intf_data.message.meta.addr = 32'($urandom_range(0, 1));
      intf_data.message.data      = {32'($urandom), 32'($urandom)};
      rq_valid = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0:       set_req($urandom_range(0, 9) < 3, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 1)), MASK_ALL);
        1:       set_req($urandom_range(0, 9) < 3, 32'($urandom_range(0, 3)), 32'h0, MASK_TAG);
        default: set_req($urandom_range(0, 9) < 3, 32'h0, 32'h0, 64'd0);
      endcase
      wb_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    rst        = 1'b0;
    intf_valid = 1'b0;
    rq_valid   = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
